action_sequencer: RTL and testbench

Sequencing controller for the lab5 image-transform datapath.
- Latches the image size during the image load phase.
- Collects each action set delivered under `in_valid2` into a small queue.
- Replays the queue: issues one datapath op at a time over a start/done handshake, and folds flip and negative into flags instead of spending datapath passes.
- Sits between the top-level input port and the transform datapath; it owns no image data.

---
 rtl/lab5_pkg.sv | 27 ++
 rtl/act_fifo.sv | 61 ++++++
 rtl/action_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_action_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lab5_pkg.sv
// Shared constants and types for the lab5 action sequencer.
package lab5_pkg;

    // Action codes as delivered on the action input; codes 5-7 are illegal.
    localparam logic [2:0] ACT_MAXPOOL  = 3'd0;
    localparam logic [2:0] ACT_NEGATIVE = 3'd1;
    localparam logic [2:0] ACT_HFLIP    = 3'd2;
    localparam logic [2:0] ACT_FILTER   = 3'd3;
    localparam logic [2:0] ACT_XCORR    = 3'd4;

    // Image size codes.
    localparam logic [1:0] SZ_4  = 2'd0;
    localparam logic [1:0] SZ_8  = 2'd1;
    localparam logic [1:0] SZ_16 = 2'd2;

    // Default number of non-terminator entries per action set.
    localparam int MAX_ACT_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_FINAL   = 3'd4
    } state_t;

endpackage

// File: rtl/act_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and occupancy count.
module act_fifo #(
    parameter int DEPTH = 9,
    parameter int W     = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH, which need not be a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage array; contents are only meaningful where the pointers say so, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/action_sequencer.sv
// Sequencing controller: collects an action set, then replays it as datapath ops,
// folding hflip/negative into parity flags and shrinking the size on each maxpool.
//
// Datapath handshake: op_valid is a one-cycle start pulse carrying op_code/op_size/
// op_flip/op_neg; the datapath answers with a one-cycle op_done pulse. Only one op
// is ever outstanding, and op_done is ignored unless an op is outstanding.
module action_sequencer
    import lab5_pkg::*;
#(
    parameter int MAX_ACT = MAX_ACT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [1:0] image_size,
    input  logic       in_valid2,
    input  logic [2:0] action,
    output logic       op_valid,
    output logic [2:0] op_code,
    output logic [1:0] op_size,
    output logic       op_flip,
    output logic       op_neg,
    input  logic       op_done,
    output logic       busy,
    output logic       set_done,
    output logic       ovf,
    output state_t     dbg_state
);

    // One extra slot is kept free for the terminator so a set always ends cleanly.
    localparam int DEPTH = MAX_ACT + 1;
    localparam int CW    = $clog2(DEPTH + 1);

    state_t     state_q;
    logic       in_valid_q, in_valid2_q;
    logic [1:0] base_size_q, cur_size_q;
    logic       flip_q, neg_q;
    logic       ovf_q, set_done_q;
    logic [2:0] op_code_q;
    logic [1:0] op_size_q;
    logic       op_flip_q, op_neg_q;

    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [2:0]    head;

    logic accept_window, legal, is_term, room;
    logic push, drop, issue, fire;

    // A set opens on a rising in_valid2 in IDLE and continues on any in_valid2 while collecting.
    assign accept_window = ((state_q == ST_IDLE) && in_valid2 && !in_valid2_q) ||
                           ((state_q == ST_COLLECT) && in_valid2);
    assign legal   = (action <= ACT_XCORR);
    assign is_term = (action == ACT_XCORR);
    assign room    = (int'(fifo_count) < MAX_ACT);
    assign push    = accept_window && legal && !fifo_full && (is_term || room);
    assign drop    = accept_window && legal && !is_term && !room;

    // Every ISSUE cycle consumes one entry; only real datapath work raises op_valid.
    assign issue = (state_q == ST_ISSUE) && !fifo_empty;
    assign fire  = issue && ((head == ACT_FILTER) || (head == ACT_XCORR) ||
                             ((head == ACT_MAXPOOL) && (cur_size_q != 2'd0)));

    // op_valid comes straight from the registered state and queue head so the first op can
    // start in the cycle after the terminator; attributes show the live values during the
    // pulse and hold them afterwards until the next op.
    assign op_valid = fire;
    assign op_code  = fire ? head       : op_code_q;
    assign op_size  = fire ? cur_size_q : op_size_q;
    assign op_flip  = fire ? flip_q     : op_flip_q;
    assign op_neg   = fire ? neg_q      : op_neg_q;

    assign busy      = (state_q != ST_IDLE);
    assign set_done  = set_done_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

    act_fifo #(
        .DEPTH (DEPTH),
        .W     (3),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (action),
        .pop_i   (issue),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Controller FSM with size latch, parity flags, overflow flag and held op attributes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_valid_q  <= 1'b0;
            in_valid2_q <= 1'b0;
            base_size_q <= SZ_4;
            cur_size_q  <= SZ_4;
            flip_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            set_done_q  <= 1'b0;
            op_code_q   <= 3'd0;
            op_size_q   <= 2'd0;
            op_flip_q   <= 1'b0;
            op_neg_q    <= 1'b0;
        end else begin
            in_valid_q  <= in_valid;
            in_valid2_q <= in_valid2;
            set_done_q  <= 1'b0;

            // Image size is only meaningful on the first cycle of the load phase.
            if (in_valid && !in_valid_q) begin
                base_size_q <= image_size;
            end

            if (drop) begin
                ovf_q <= 1'b1;
            end

            if (fire) begin
                op_code_q <= head;
                op_size_q <= cur_size_q;
                op_flip_q <= flip_q;
                op_neg_q  <= neg_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (in_valid2 && !in_valid2_q) begin
                        cur_size_q <= base_size_q;
                        flip_q     <= 1'b0;
                        neg_q      <= 1'b0;
                        state_q    <= (push && is_term) ? ST_ISSUE : ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (push && is_term) begin
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue) begin
                        case (head)
                            ACT_NEGATIVE: neg_q  <= ~neg_q;
                            ACT_HFLIP:    flip_q <= ~flip_q;
                            ACT_MAXPOOL: begin
                                if (cur_size_q != 2'd0) begin
                                    cur_size_q <= cur_size_q - 2'd1;
                                    state_q    <= ST_WAIT;
                                end
                            end
                            ACT_FILTER:   state_q <= ST_WAIT;
                            ACT_XCORR:    state_q <= ST_FINAL;
                            default: ;
                        endcase
                    end
                end
                ST_WAIT: begin
                    if (op_done) begin
                        state_q <= ST_ISSUE;
                    end
                end
                ST_FINAL: begin
                    if (op_done) begin
                        set_done_q <= 1'b1;
                        flip_q     <= 1'b0;
                        neg_q      <= 1'b0;
                        cur_size_q <= base_size_q;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_action_sequencer.sv
// Directed bench for action_sequencer with a datapath responder and an op scoreboard.
module tb_action_sequencer;
    import lab5_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] image_size = 2'd0;
    logic       in_valid2 = 1'b0;
    logic [2:0] action = 3'd0;
    logic       op_done;
    logic       op_valid;
    logic [2:0] op_code;
    logic [1:0] op_size;
    logic       op_flip, op_neg;
    logic       busy, set_done, ovf;
    state_t     dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    action_sequencer #(.MAX_ACT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .image_size (image_size),
        .in_valid2  (in_valid2),
        .action     (action),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .op_size    (op_size),
        .op_flip    (op_flip),
        .op_neg     (op_neg),
        .op_done    (op_done),
        .busy       (busy),
        .set_done   (set_done),
        .ovf        (ovf),
        .dbg_state  (dbg_state)
    );

    // ---------------- monitor / scoreboard ----------------
    logic [6:0] obs_q[$];
    int         obs_cyc[$];
    logic [6:0] exp_q[$];
    int         done_cnt = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    always @(negedge clk) begin
        if (op_valid) begin
            obs_q.push_back({op_code, op_size, op_flip, op_neg});
            obs_cyc.push_back(cyc);
        end
        if (set_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] pk(input logic [2:0] c, input logic [1:0] s,
                                      input logic f, input logic n);
        return {c, s, f, n};
    endfunction

    task automatic check_ops(input string tag, input int base);
        check({tag, "_count"}, obs_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < obs_q.size()) check({tag, "_op"}, {25'd0, obs_q[base + i]}, {25'd0, exp_q[i]});
            else check({tag, "_op_missing"}, 32'hffff_ffff, {25'd0, exp_q[i]});
        end
    endtask

    // ---------------- datapath responder ----------------
    logic resp_en = 1'b1;
    int   late_req = 0;
    int   late_ack = 0;

    initial begin
        op_done = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en && op_valid) begin
                repeat (2) @(posedge clk);
                #1 op_done = 1'b1;
                @(posedge clk);
                #1 op_done = 1'b0;
            end else if (late_req != late_ack) begin
                late_ack++;
                @(posedge clk);
                #1 op_done = 1'b1;
                @(posedge clk);
                #1 op_done = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [2:0] act_q[$];
    int         term_cyc = 0;

    task automatic load_image(input logic [1:0] sz);
        @(posedge clk); #1 in_valid = 1'b1; image_size = sz;
        repeat (3) begin
            @(posedge clk); #1 image_size = ~sz;
        end
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    task automatic send_set(input int gap_idx);
        for (int i = 0; i < act_q.size(); i++) begin
            if (i == gap_idx) begin
                @(posedge clk); #1 in_valid2 = 1'b0;
                @(posedge clk); #1 in_valid2 = 1'b0;
            end
            @(posedge clk); #1 in_valid2 = 1'b1; action = act_q[i];
            if (act_q[i] == ACT_XCORR) term_cyc = cyc;
        end
        @(posedge clk); #1 in_valid2 = 1'b0; action = 3'd0;
    endtask

    task automatic wait_set_done(input string tag, input int start);
        int t = 0;
        while (done_cnt == start && t < 400) begin
            @(posedge clk); t++;
        end
        #1;
        check({tag, "_set_done"}, done_cnt - start, 1);
        check({tag, "_busy_low"}, busy, 1'b0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int b, d, t;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_op_valid", op_valid, 1'b0);
        check("rst_op_code", op_code, 3'd0);
        check("rst_op_size", op_size, 2'd0);
        check("rst_flags", {op_flip, op_neg}, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_set_done", set_done, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_state", dbg_state, ST_IDLE);

        // Size 16x16, two maxpools shrink the size, xcorr ends at 4x4.
        load_image(SZ_16);
        act_q = '{3'd0, 3'd0, 3'd4};
        b = obs_q.size(); d = done_cnt;
        send_set(-1);
        wait_set_done("t1", d);
        exp_q = '{pk(3'd0, 2'd2, 1'b0, 1'b0), pk(3'd0, 2'd1, 1'b0, 1'b0), pk(3'd4, 2'd0, 1'b0, 1'b0)};
        check_ops("t1", b);

        // Size 4x4: maxpool is skipped, filter and xcorr run at size 0.
        load_image(SZ_4);
        act_q = '{3'd0, 3'd3, 3'd4};
        b = obs_q.size(); d = done_cnt;
        send_set(-1);
        wait_set_done("t2", d);
        exp_q = '{pk(3'd3, 2'd0, 1'b0, 1'b0), pk(3'd4, 2'd0, 1'b0, 1'b0)};
        check_ops("t2", b);
        check("t2_ovf", ovf, 1'b0);

        // Flags only: flip toggles twice, neg three times; xcorr 6 cycles after terminator.
        load_image(SZ_8);
        act_q = '{3'd2, 3'd1, 3'd2, 3'd1, 3'd1, 3'd4};
        b = obs_q.size(); d = done_cnt;
        send_set(-1);
        wait_set_done("t3", d);
        exp_q = '{pk(3'd4, 2'd1, 1'b0, 1'b1)};
        check_ops("t3", b);
        if (obs_q.size() > b) check("t3_latency", obs_cyc[b] - term_cyc, 6);
        else check("t3_latency_missing", 32'hffff_ffff, 6);

        // Overflow: 7 filters + neg kept, hflip and 10th filter dropped.
        act_q = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd1, 3'd2, 3'd3, 3'd4};
        b = obs_q.size(); d = done_cnt;
        send_set(-1);
        wait_set_done("t4", d);
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(pk(3'd3, 2'd1, 1'b0, 1'b0));
        exp_q.push_back(pk(3'd4, 2'd1, 1'b0, 1'b1));
        check_ops("t4", b);
        check("t4_ovf", ovf, 1'b1);

        // Second set: size restarts at base (8x8) although image_size moved without in_valid.
        image_size = SZ_4;
        act_q = '{3'd0, 3'd4};
        b = obs_q.size(); d = done_cnt;
        send_set(-1);
        wait_set_done("t5", d);
        exp_q = '{pk(3'd0, 2'd1, 1'b0, 1'b0), pk(3'd4, 2'd0, 1'b0, 1'b0)};
        check_ops("t5", b);
        check("t5_ovf_sticky", ovf, 1'b1);

        // in_valid2 gap inside a set: collection resumes.
        act_q = '{3'd3, 3'd1, 3'd4};
        b = obs_q.size(); d = done_cnt;
        send_set(1);
        wait_set_done("t6", d);
        exp_q = '{pk(3'd3, 2'd1, 1'b0, 1'b0), pk(3'd4, 2'd1, 1'b0, 1'b1)};
        check_ops("t6", b);

        // Reset while waiting for op_done; a late op_done must not complete anything.
        resp_en = 1'b0;
        act_q = '{3'd3, 3'd4};
        b = obs_q.size();
        send_set(-1);
        t = 0;
        while (dbg_state != ST_WAIT && t < 20) begin
            @(negedge clk); t++;
        end
        check("t7_in_wait", dbg_state, ST_WAIT);
        check("t7_one_op", obs_q.size() - b, 1);
        @(posedge clk); #2 rst = 1'b1;
        @(negedge clk);
        check("t7_rst_op_valid", op_valid, 1'b0);
        check("t7_rst_op_code", op_code, 3'd0);
        check("t7_rst_op_size", op_size, 2'd0);
        check("t7_rst_flags", {op_flip, op_neg}, 2'b00);
        check("t7_rst_busy", busy, 1'b0);
        check("t7_rst_ovf", ovf, 1'b0);
        check("t7_rst_state", dbg_state, ST_IDLE);
        @(posedge clk); #1 rst = 1'b0;
        d = done_cnt;
        late_req++;
        repeat (10) @(posedge clk);
        #1;
        check("t7_no_set_done", done_cnt - d, 0);
        check("t7_idle_busy", busy, 1'b0);
        check("t7_no_new_op", obs_q.size() - b, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
